// File: rtl/updown_counter.sv
// updown_counter: parametrised signed up/down counter with load, overflow and zero flags.
// Define UPDOWN_COUNTER_SAT_EN to clamp at the signed limits instead of wrapping.
module updown_counter #(
   parameter int WIDTH     = 16,
   parameter int STEP      = 1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             res,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] o,
   output logic             ovf,
   output logic             zero
);
   logic [WIDTH:0]   ext, sum;
   logic [WIDTH-1:0] nxt;
   logic             count, of;
   always_comb begin
      ext   = {o[WIDTH-1], o};
      count = inc ^ dec;
      sum   = inc ? ext + (WIDTH+1)'(STEP) : ext - (WIDTH+1)'(STEP);
      // the extra bit disagreeing with the sign bit means the result left the signed range
      of    = count && !load && (sum[WIDTH] != sum[WIDTH-1]);
`ifdef UPDOWN_COUNTER_SAT_EN
      nxt   = load ? in : !count ? o : of ? (inc ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}}) : sum[WIDTH-1:0];
`else
      nxt   = load ? in : count ? sum[WIDTH-1:0] : o;
`endif
   end
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         o    <= WIDTH'(RESET_VAL);
         ovf  <= 1'b0;
         zero <= (RESET_VAL == 0);
      end else begin
         o    <= nxt;
         ovf  <= of;
         zero <= (nxt == '0);
      end
   end
endmodule
